mem_lsu: RTL and testbench

MEM_LSU -- requirements
Module: mem_lsu

---
 rtl/mem_lsu_pkg.sv | 9 +
 rtl/lsu_align.sv | 25 ++
 rtl/mem_lsu.sv | 82 ++++++++
 tb/tb_mem_lsu.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: request size/extension encodings and FSM state type shared by the LSU.
package mem_lsu_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL = 2'b11;
  localparam int UNS_BIT = 2;
  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: store lane mask/data positioning and load extraction/extension over a two-word window.
module lsu_align
  import mem_lsu_pkg::*;
(
  input  logic [2:0]  kind,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [63:0] rword,
  output logic [7:0]  mask,
  output logic [63:0] wlanes,
  output logic [31:0] rdata
);
  logic [7:0] base;
  logic [31:0] sh;
  logic sx;
  always_comb begin
    base = kind[1:0] == SZ_BYTE ? 8'h01 : kind[1:0] == SZ_HALF ? 8'h03 : kind[1:0] == SZ_WORD ? 8'h0f : 8'h00;
    mask = base << off;
    wlanes = {32'b0, wdata} << {off, 3'b000};
    sh = 32'(rword >> {off, 3'b000});
    sx = ~kind[UNS_BIT];
    rdata = kind[1:0] == SZ_BYTE ? {{24{sx & sh[7]}}, sh[7:0]} :
            kind[1:0] == SZ_HALF ? {{16{sx & sh[15]}}, sh[15:0]} : sh;
  end
endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: load/store unit splitting misaligned accesses into two word accesses on a simple memory port.
module mem_lsu
  import mem_lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic        mem_re,
  output logic        mem_we,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  state_t state;
  logic we_r;
  logic [2:0] type_r;
  logic [31:0] addr_r, wdata_r, lo, ld;
  logic [7:0] mask;
  logic [63:0] wl;
  logic mis, hi, acc;
  lsu_align u_align (
    .kind(type_r),
    .off(addr_r[1:0]),
    .wdata(wdata_r),
    .rword(hi ? {mem_rdata, lo} : {32'b0, mem_rdata}),
    .mask(mask),
    .wlanes(wl),
    .rdata(ld)
  );
  assign req_ready = state == IDLE;
  assign resp_valid = state == RESP;
  // rst gates the strobes so an aborted split access never touches its second word
  always_comb begin
    hi = state == ACC1;
    acc = (state == ACC0 || hi) && !rst;
    mis = (type_r[1:0] == SZ_HALF && addr_r[1:0] == 2'b11) || (type_r[1:0] == SZ_WORD && addr_r[1:0] != 2'b00);
    mem_addr = state == ACC0 ? {addr_r[31:2], 2'b00} : hi ? {addr_r[31:2], 2'b00} + 32'd4 : 32'b0;
    mem_re = acc && !we_r;
    mem_we = acc && we_r && (hi ? |mask[7:4] : 1'b1);
    mem_wstrb = mem_we ? (hi ? mask[7:4] : mask[3:0]) : 4'b0;
    mem_wdata = mem_we ? (hi ? wl[63:32] : wl[31:0]) : 32'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      resp_err <= 1'b0;
      resp_rdata <= 32'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          we_r <= req_we;
          type_r <= req_type;
          addr_r <= req_addr;
          wdata_r <= req_wdata;
          resp_err <= req_type[1:0] == SZ_ILL;
          resp_rdata <= 32'b0;
          state <= req_type[1:0] == SZ_ILL ? RESP : ACC0;
        end
        ACC0: begin
          lo <= mem_rdata;
          resp_rdata <= we_r ? 32'b0 : ld;
          state <= mis ? ACC1 : RESP;
        end
        ACC1: begin
          resp_rdata <= we_r ? 32'b0 : ld;
          state <= RESP;
        end
        RESP: if (resp_ready) state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed self-checking bench for mem_lsu with a small word memory model.
module tb_mem_lsu;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_ready, req_we = 0;
  logic [2:0] req_type = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic resp_valid, resp_ready = 0, resp_err;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic mem_re, mem_we;
  logic [3:0] mem_wstrb;
  logic [31:0] mem_arr [8];
  int n_tests = 0, n_fail = 0;
  int lat, n_re, n_we, bad;
  logic [31:0] a_log [2];
  logic [31:0] s_log [2];
  logic [31:0] d_log [2];

  mem_lsu dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_addr(mem_addr),
    .mem_re(mem_re), .mem_we(mem_we), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  assign mem_rdata = mem_arr[{mem_addr[8], mem_addr[3:2]}];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic we, input logic [2:0] t, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req_valid = 1; req_we = we; req_type = t; req_addr = a; req_wdata = d;
    @(posedge clk);
    #1 req_valid = 0;
    lat = 0; n_re = 0; n_we = 0; bad = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = i;
        break;
      end
      if ((mem_re && mem_we) || req_ready) bad++;
      if (mem_re || mem_we) begin
        if (n_re + n_we < 2) begin
          a_log[n_re + n_we] = mem_addr;
          s_log[n_re + n_we] = {28'b0, mem_wstrb};
          d_log[n_re + n_we] = mem_wdata;
        end
        n_re += int'(mem_re);
        n_we += int'(mem_we);
      end
    end
    if (lat != 0 && (mem_re || mem_we || req_ready)) bad++;
  endtask

  task automatic consume;
    resp_ready = 1;
    @(posedge clk);
    #1 resp_ready = 0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem_arr[i] = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 1);
    chk("rst_resp", {29'b0, resp_valid, resp_err, mem_re | mem_we}, 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_maddr", mem_addr, 0);
    chk("rst_mwdata_strb", mem_wdata | {28'b0, mem_wstrb}, 0);

    xfer(1, 3'b010, 32'h100, 32'hDEADBEEF);
    chk("sw_lat", lat, 2);
    chk("sw_counts", {n_re[15:0], n_we[15:0]}, 32'h0000_0001);
    chk("sw_addr", a_log[0], 32'h100);
    chk("sw_strb", s_log[0], 32'hF);
    chk("sw_data", d_log[0], 32'hDEADBEEF);
    chk("sw_resp", {resp_err, resp_rdata[30:0]}, 0);
    chk("sw_bad", bad, 0);
    consume();

    mem_arr[4] = 32'h80AABBCC;
    xfer(0, 3'b000, 32'h103, 0);
    chk("lb_lat", lat, 2);
    chk("lb_counts", {n_re[15:0], n_we[15:0]}, 32'h0001_0000);
    chk("lb_addr", a_log[0], 32'h100);
    chk("lb_rdata", resp_rdata, 32'hFFFFFF80);
    consume();
    xfer(0, 3'b100, 32'h103, 0);
    chk("lbu_rdata", resp_rdata, 32'h00000080);
    consume();
    xfer(0, 3'b001, 32'h101, 0);
    chk("lh_rdata", resp_rdata, 32'hFFFFAABB);
    chk("lh_lat", lat, 2);
    consume();

    mem_arr[4] = 32'h11223344;
    mem_arr[5] = 32'h55667788;
    xfer(0, 3'b010, 32'h102, 0);
    chk("lw_mis_lat", lat, 3);
    chk("lw_mis_counts", {n_re[15:0], n_we[15:0]}, 32'h0002_0000);
    chk("lw_mis_a0", a_log[0], 32'h100);
    chk("lw_mis_a1", a_log[1], 32'h104);
    chk("lw_mis_rdata", resp_rdata, 32'h77881122);
    chk("lw_mis_bad", bad, 0);
    consume();

    xfer(1, 3'b001, 32'hFFFFFFFF, 32'h0000ABCD);
    chk("sh_wrap_lat", lat, 3);
    chk("sh_wrap_counts", {n_re[15:0], n_we[15:0]}, 32'h0000_0002);
    chk("sh_wrap_a0", a_log[0], 32'hFFFFFFFC);
    chk("sh_wrap_s0", s_log[0], 32'h8);
    chk("sh_wrap_d0", d_log[0], 32'hCD000000);
    chk("sh_wrap_a1", a_log[1], 32'h0);
    chk("sh_wrap_s1", s_log[1], 32'h1);
    chk("sh_wrap_d1", d_log[1], 32'h000000AB);
    consume();

    xfer(0, 3'b011, 32'h100, 0);
    chk("ill_lat", lat, 1);
    chk("ill_strobes", n_re + n_we, 0);
    chk("ill_err", {31'b0, resp_err}, 1);
    chk("ill_rdata", resp_rdata, 0);
    consume();
    @(negedge clk);
    chk("ill_cleared", {30'b0, resp_valid, req_ready}, 1);

    xfer(0, 3'b101, 32'h104, 0);
    chk("bp_lat", lat, 2);
    for (int i = 0; i < 5; i++) begin
      chk("bp_rdata", resp_rdata, 32'h00007788);
      chk("bp_flags", {28'b0, resp_valid, req_ready, mem_re, mem_we}, 32'h8);
      @(negedge clk);
    end
    consume();

    @(negedge clk);
    req_valid = 1; req_we = 0; req_type = 3'b010; req_addr = 32'h102;
    @(posedge clk);
    #1 req_valid = 0;
    @(negedge clk);
    chk("rst_acc0", {mem_re, mem_addr[30:0]}, 32'h80000100);
    @(negedge clk);
    chk("rst_acc1_addr", mem_addr, 32'h104);
    rst = 1;
    #1 chk("rst_acc1_nostrobe", {31'b0, mem_re | mem_we}, 0);
    @(posedge clk);
    #1 rst = 0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (resp_valid || !req_ready || mem_re || mem_we) bad++;
    end
    chk("rst_abort", bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
